// File: rtl/vga_timing_rx.sv
// vga_timing_rx
// Receive-side timing recovery for an SVGA 800x600@60 stream on the 40 MHz
// pixel clock. Samples the incoming syncs and pixel data, recovers pixel
// coordinates with a data-valid strobe, measures line and frame timing and
// reports lock once consecutive frames match the nominal parameters.
//
// Ports:
//   clk40m      in   1   pixel clock
//   rst         in   1   asynchronous reset, active-low
//   hs_in       in   1   horizontal sync, active-low pulse
//   vs_in       in   1   vertical sync, active-low pulse
//   rgb_in      in  30   {r[9:0],g[9:0],b[9:0]} pixel data
//   pix_valid   out  1   active pixel present on pix_rgb
//   pix_x       out 10   active column
//   pix_y       out 10   active row
//   pix_rgb     out 30   registered pixel data
//   frame_start out  1   one-clock pulse following each vsync falling edge
//   locked      out  1   timing matches the parameters
//   line_len    out 11   last measured hsync period in clocks
//   frame_lines out 10   last measured lines per frame
//   err_cnt     out  8   bad-frame count, saturating at 255
module vga_timing_rx #(
  parameter int H_TOTAL     = 1056,
  parameter int H_PULSE     = 128,
  parameter int H_START     = 216,
  parameter int H_ACTIVE    = 800,
  parameter int V_TOTAL     = 628,
  parameter int V_START     = 27,
  parameter int V_ACTIVE    = 600,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk40m,
  input  logic        rst,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic [29:0] rgb_in,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [29:0] pix_rgb,
  output logic        frame_start,
  output logic        locked,
  output logic [10:0] line_len,
  output logic [9:0]  frame_lines,
  output logic [7:0]  err_cnt
);

  localparam logic [11:0] H_TOTAL_L = 12'(H_TOTAL);
  localparam logic [11:0] H_PULSE_L = 12'(H_PULSE);
  localparam logic [10:0] H_START_L = 11'(H_START);
  localparam logic [10:0] H_END_L   = 11'(H_START + H_ACTIVE);
  localparam logic [9:0]  V_TOTAL_L = 10'(V_TOTAL);
  localparam logic [9:0]  V_START_L = 10'(V_START);
  localparam logic [9:0]  V_END_L   = 10'(V_START + V_ACTIVE);
  localparam int          GW        = (LOCK_FRAMES < 1) ? 1 : $clog2(LOCK_FRAMES + 1);
  localparam logic [GW-1:0] LOCK_L  = GW'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t state_reg, state_next;
  logic [GW-1:0] good_cnt_reg, good_cnt_next;
  logic          err_inc;

  // Input sampling stage and one-cycle history for edge detection
  logic        hs_q, vs_q, hs_d, vs_d;
  logic [29:0] rgb_q;

  logic [10:0] h_cnt;
  logic [9:0]  v_cnt;
  logic        frame_err;

  logic        hs_fall, hs_rise, vs_fall;
  logic [11:0] h_len;
  logic        timeout;
  logic        frame_good;
  logic        h_act, v_act, pix_hit;

  assign hs_fall = hs_d & ~hs_q;
  assign hs_rise = ~hs_d & hs_q;
  assign vs_fall = vs_d & ~vs_q;

  // Length of the interval that ends on this cycle's edge; one bit wider so
  // that a saturated counter does not wrap to zero.
  assign h_len      = {1'b0, h_cnt} + 12'd1;
  assign timeout    = (h_cnt == 11'h7FF);
  assign frame_good = (v_cnt == V_TOTAL_L) && !frame_err;

  assign h_act   = (h_cnt >= H_START_L) && (h_cnt < H_END_L);
  assign v_act   = (v_cnt >= V_START_L) && (v_cnt < V_END_L);
  assign pix_hit = locked & h_act & v_act;

  // Lock FSM: next state, good-frame count and bad-frame strobe.
  // Signal loss overrides any frame evaluation in the same cycle.
  always_comb begin
    state_next    = state_reg;
    good_cnt_next = good_cnt_reg;
    err_inc       = 1'b0;
    if (timeout) begin
      state_next    = SEARCH;
      good_cnt_next = '0;
    end else if (vs_fall) begin
      case (state_reg)
        SEARCH: begin
          state_next    = CHECK;
          good_cnt_next = '0;
        end
        CHECK: begin
          if (frame_good) begin
            good_cnt_next = good_cnt_reg + GW'(1);
            if (good_cnt_next == LOCK_L) begin
              state_next = LOCKED;
            end
          end else begin
            good_cnt_next = '0;
            err_inc       = 1'b1;
          end
        end
        LOCKED: begin
          if (!frame_good) begin
            state_next    = CHECK;
            good_cnt_next = '0;
            err_inc       = 1'b1;
          end
        end
        default: begin
          state_next    = SEARCH;
          good_cnt_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk40m or negedge rst) begin
    if (!rst) begin
      state_reg    <= SEARCH;
      good_cnt_reg <= '0;
      locked       <= 1'b0;
      err_cnt      <= '0;
    end else begin
      state_reg    <= state_next;
      good_cnt_reg <= good_cnt_next;
      locked       <= (state_next == LOCKED);
      if (err_inc && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

  // Sync sampling, counters and timing measurements
  always_ff @(posedge clk40m or negedge rst) begin
    if (!rst) begin
      // Syncs reset low so that only a genuine high-to-low transition after
      // release can be seen as a falling edge.
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      hs_d        <= 1'b0;
      vs_d        <= 1'b0;
      rgb_q       <= '0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_err   <= 1'b0;
      line_len    <= '0;
      frame_lines <= '0;
      frame_start <= 1'b0;
    end else begin
      hs_q  <= hs_in;
      vs_q  <= vs_in;
      hs_d  <= hs_q;
      vs_d  <= vs_q;
      rgb_q <= rgb_in;

      if (hs_fall) begin
        h_cnt <= '0;
      end else if (!timeout) begin
        h_cnt <= h_cnt + 11'd1;
      end

      // After signal loss the measured period exceeds the field width;
      // report it pinned at the maximum rather than wrapped.
      if (hs_fall) begin
        line_len <= h_len[11] ? 11'h7FF : h_len[10:0];
      end

      // A frame boundary takes priority over a coincident line increment
      if (vs_fall) begin
        v_cnt       <= '0;
        frame_lines <= v_cnt;
      end else if (hs_fall && (v_cnt != 10'h3FF)) begin
        v_cnt <= v_cnt + 10'd1;
      end

      if (vs_fall) begin
        frame_err <= 1'b0;
      end else if ((state_reg != SEARCH) &&
                   ((hs_fall && (h_len != H_TOTAL_L)) ||
                    (hs_rise && (h_len != H_PULSE_L)))) begin
        frame_err <= 1'b1;
      end

      frame_start <= vs_fall;
    end
  end

  // Pixel output stage: coordinates and data load together, so all three
  // hold their last active value through blanking.
  always_ff @(posedge clk40m or negedge rst) begin
    if (!rst) begin
      pix_valid <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_rgb   <= '0;
    end else begin
      pix_valid <= pix_hit;
      if (pix_hit) begin
        pix_x   <= 10'(h_cnt - H_START_L);
        pix_y   <= 10'(v_cnt - V_START_L);
        pix_rgb <= rgb_q;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_rx.sv
`timescale 1ns/1ps
// Testbench for vga_timing_rx using a reduced raster so that many frames fit
// in a short run. A bench-side sync generator drives the DUT; every active
// pixel it sends while lock is expected is queued and matched against the
// DUT output stream.
module tb_vga_timing_rx;

  localparam int H_TOTAL     = 32;
  localparam int H_PULSE     = 4;
  localparam int H_START     = 8;
  localparam int H_ACTIVE    = 20;
  localparam int V_TOTAL     = 14;
  localparam int V_PULSE     = 2;
  localparam int V_START     = 2;
  localparam int V_ACTIVE    = 8;
  localparam int LOCK_FRAMES = 2;

  logic        clk40m = 1'b0;
  logic        rst    = 1'b0;
  logic        hs_in  = 1'b1;
  logic        vs_in  = 1'b1;
  logic [29:0] rgb_in = '0;
  logic        pix_valid;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [29:0] pix_rgb;
  logic        frame_start;
  logic        locked;
  logic [10:0] line_len;
  logic [9:0]  frame_lines;
  logic [7:0]  err_cnt;

  int checks   = 0;
  int failures = 0;
  int vcnt     = 0;
  int fs_cnt   = 0;
  bit cur_exp  = 1'b0;
  logic vs_d1  = 1'b1;
  logic vs_d2  = 1'b1;
  logic [49:0] exp_q[$];

  always #12.5 clk40m = ~clk40m;

  vga_timing_rx #(
    .H_TOTAL(H_TOTAL), .H_PULSE(H_PULSE), .H_START(H_START),
    .H_ACTIVE(H_ACTIVE), .V_TOTAL(V_TOTAL), .V_START(V_START),
    .V_ACTIVE(V_ACTIVE), .LOCK_FRAMES(LOCK_FRAMES)
  ) dut (
    .clk40m(clk40m), .rst(rst), .hs_in(hs_in), .vs_in(vs_in),
    .rgb_in(rgb_in), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .pix_rgb(pix_rgb), .frame_start(frame_start), .locked(locked),
    .line_len(line_len), .frame_lines(frame_lines), .err_cnt(err_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pix_valid"},   64'(pix_valid),   64'd0);
    chk({tag, "_pix_x"},       64'(pix_x),       64'd0);
    chk({tag, "_pix_y"},       64'(pix_y),       64'd0);
    chk({tag, "_pix_rgb"},     64'(pix_rgb),     64'd0);
    chk({tag, "_frame_start"}, 64'(frame_start), 64'd0);
    chk({tag, "_locked"},      64'(locked),      64'd0);
    chk({tag, "_line_len"},    64'(line_len),    64'd0);
    chk({tag, "_frame_lines"}, 64'(frame_lines), 64'd0);
    chk({tag, "_err_cnt"},     64'(err_cnt),     64'd0);
  endtask

  // Output monitor: pops one expected pixel per pix_valid cycle
  always @(negedge clk40m) begin
    if (frame_start) fs_cnt++;
    if (pix_valid) begin
      vcnt++;
      chk("pix_pending", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        logic [49:0] e;
        e = exp_q.pop_front();
        chk("pix_xy_rgb", 64'({pix_x, pix_y, pix_rgb}), 64'(e));
      end
    end
  end

  // One pixel clock of stimulus; vsync is delayed two clocks so its edges
  // never coincide with an hsync falling edge.
  task automatic step(input logic hs, input logic vs_raw, input logic [29:0] rgb);
    hs_in  = hs;
    vs_in  = vs_d2;
    vs_d2  = vs_d1;
    vs_d1  = vs_raw;
    rgb_in = rgb;
    @(posedge clk40m);
    #1;
  endtask

  task automatic gen_line(input int vline, input int len, input int rst_at);
    int rel;
    rel = -1;
    for (int gh = 0; gh < len; gh++) begin
      logic [9:0] px;
      logic [9:0] py;
      if (gh == rst_at) begin
        rst = 1'b0;
        #1;
        chk_zero("rst_mid");
        exp_q.delete();
        cur_exp = 1'b0;
        rel = gh + 3;
      end
      if (gh == rel) rst = 1'b1;
      px = 10'(gh - H_START - 1);
      py = 10'(vline - V_START);
      if (cur_exp && gh >= H_START + 1 && gh <= H_START + H_ACTIVE &&
          vline >= V_START && vline < V_START + V_ACTIVE)
        exp_q.push_back({px, py, px, py, px ^ py});
      step(gh >= H_PULSE, vline >= V_PULSE, {px, py, px ^ py});
    end
  endtask

  // One frame; expectations < 0 are skipped
  task automatic gen_frame(input int nlines, input int short_line, input bit exp_lock,
                           input int exp_err, input int exp_fl, input int rst_line,
                           input bit count_px);
    cur_exp = exp_lock;
    vcnt    = 0;
    fs_cnt  = 0;
    for (int vl = 0; vl < nlines; vl++) begin
      if (vl == 1) begin
        chk("locked", 64'(locked), 64'(exp_lock));
        if (exp_err >= 0) chk("err_cnt", 64'(err_cnt), 64'(exp_err));
        if (exp_fl >= 0) chk("frame_lines", 64'(frame_lines), 64'(exp_fl));
      end
      if (short_line >= 0 && vl == short_line + 2)
        chk("line_len_short", 64'(line_len), 64'(H_TOTAL - 1));
      else if (vl == 2)
        chk("line_len", 64'(line_len), 64'(H_TOTAL));
      gen_line(vl, (vl == short_line) ? H_TOTAL - 1 : H_TOTAL,
               (vl == rst_line) ? H_START + 6 : -1);
    end
    chk("frame_start_cnt", 64'(fs_cnt), 64'd1);
    if (count_px) chk("valid_count", 64'(vcnt), 64'(H_ACTIVE * V_ACTIVE));
  endtask

  initial begin
    int hold_vcnt;
    repeat (3) @(posedge clk40m);
    #1;
    chk_zero("rst_init");
    rst = 1'b1;
    gen_line(V_TOTAL - 1, H_TOTAL, -1);

    // Ideal timing: lock after the third vsync fall
    gen_frame(V_TOTAL, -1, 0, 0, -1,      -1, 0);
    gen_frame(V_TOTAL, -1, 0, 0, V_TOTAL, -1, 0);
    gen_frame(V_TOTAL, -1, 1, 0, V_TOTAL, -1, 1);

    // One short line in the vertical blanking of a locked frame
    gen_frame(V_TOTAL, V_TOTAL - 3, 1, 0, V_TOTAL, -1, 1);
    gen_frame(V_TOTAL, -1, 0, 1, V_TOTAL, -1, 0);
    gen_frame(V_TOTAL, -1, 0, 1, V_TOTAL, -1, 0);
    gen_frame(V_TOTAL, -1, 1, 1, V_TOTAL, -1, 1);

    // One frame a line short
    gen_frame(V_TOTAL - 1, -1, 1, 1, V_TOTAL,     -1, 1);
    gen_frame(V_TOTAL,     -1, 0, 2, V_TOTAL - 1, -1, 0);
    gen_frame(V_TOTAL,     -1, 0, 2, V_TOTAL,     -1, 0);
    gen_frame(V_TOTAL,     -1, 1, 2, V_TOTAL,     -1, 1);

    // hsync lost: lock survives until the counter saturates
    hold_vcnt = vcnt;
    for (int i = 0; i < 3000; i++) begin
      step(1'b1, 1'b1, 30'h0);
      if (i == 1500) chk("locked_hold_mid", 64'(locked), 64'd1);
    end
    chk("locked_hold_end", 64'(locked), 64'd0);
    chk("err_cnt_hold", 64'(err_cnt), 64'd2);
    chk("valid_hold", 64'(vcnt), 64'(hold_vcnt));
    gen_frame(V_TOTAL, -1, 0, 2, V_TOTAL, -1, 0);
    gen_frame(V_TOTAL, -1, 0, 2, V_TOTAL, -1, 0);
    gen_frame(V_TOTAL, -1, 1, 2, V_TOTAL, -1, 1);

    // Reset in the middle of an active line, then full relock
    gen_frame(V_TOTAL, -1, 1, 2, V_TOTAL, V_START + 1, 0);
    gen_frame(V_TOTAL, -1, 0, 0, -1,      -1, 0);
    gen_frame(V_TOTAL, -1, 0, 0, V_TOTAL, -1, 0);
    gen_frame(V_TOTAL, -1, 1, 0, V_TOTAL, -1, 1);

    // 300 consecutive bad (3-line) frames: error count saturates
    for (int k = 1; k <= 300; k++) begin
      gen_frame(V_PULSE + 1, -1, k == 1, (k == 1) ? 0 : ((k - 1 > 255) ? 255 : k - 1),
                (k == 1) ? V_TOTAL : V_PULSE + 1, -1, 0);
    end
    gen_frame(V_TOTAL, -1, 0, 255, V_PULSE + 1, -1, 0);

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
